// File: rtl/c_grid_pkg.sv
// rtl/c_grid_pkg.sv - shared constants, op codes, FSM states and cell indexing for the C-element grid sequencer
package c_grid_pkg;

  localparam int GRID_ROWS = 3;
  localparam int GRID_COLS = 3;

  // Command op codes
  localparam logic [1:0] OP_NOP       = 2'b00;
  localparam logic [1:0] OP_SET       = 2'b01;
  localparam logic [1:0] OP_CLEAR     = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARM     = 3'd1;
  localparam state_t ST_STROBE  = 3'd2;
  localparam state_t ST_RELEASE = 3'd3;
  localparam state_t ST_SETTLE  = 3'd4;

  // Flat cell index, row-major: row*3+col
  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/c_grid_write_sequencer_hold_timer.sv
// rtl/c_grid_write_sequencer_hold_timer.sv - loadable down-counter with done flag (module c_grid_hold_timer)
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val into the counter this cycle
//   load_val    interval length in cycles (>=1)
//   done        high during the last cycle of the loaded interval
module c_grid_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A load of N gives N cycles; done marks the Nth so the FSM leaves on that edge.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/c_grid_write_sequencer.sv
// rtl/c_grid_write_sequencer.sv - orders and times row/column waveforms for the 3x3 C-element latch grid
//
// Turns SET / CLEAR / CLEAR_ALL commands into row and column line sequences
// that never raise a row while a column moves, and keeps a shadow copy of
// the grid contents. Optional feature macro: READBACK_CHECK_EN (compares the
// grid's per-column "any set" flags to the shadow on each return to idle).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only in idle
//   cmd_op/row/col        op code and target cell
//   row_o [2:0]           grid row lines
//   col_o [8:0]           grid column lines, index row*3+col
//   shadow_o [8:0]        expected grid contents
//   busy                  inverse of cmd_ready
//   cmd_err               one-cycle pulse for SET/CLEAR with index 3
//   col_any_i [2:0]       grid per-column any-set flags (readback only)
//   chk_err               sticky readback mismatch
module c_grid_write_sequencer
  import c_grid_pkg::*;
#(
  parameter int SET_HOLD = 4,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_row,
  input  logic [1:0] cmd_col,
  output logic [2:0] row_o,
  output logic [8:0] col_o,
  output logic [8:0] shadow_o,
  output logic       busy,
  output logic       cmd_err,
  input  logic [2:0] col_any_i,
  output logic       chk_err
);

  localparam int MAXV = (SET_HOLD > SETTLE) ? SET_HOLD : SETTLE;
  localparam int TW   = $clog2(MAXV + 1);

  state_t     state;
  logic [2:0] row_q;
  logic [8:0] col_q;
  logic [1:0] tgt_row;
  logic       err_q;

  logic       accept;
  logic       idx_bad;
  logic [8:0] cell_mask;
  logic       t_load;
  logic [TW-1:0] t_val;
  logic       t_done;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign idx_bad   = (cmd_row == 2'd3) || (cmd_col == 2'd3);
  assign cell_mask = 9'b1 << cell_idx(cmd_row, cmd_col);

  // Column lines and shadow move together, so a single register drives both.
  assign col_o     = col_q;
  assign shadow_o  = col_q;
  assign row_o     = row_q;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign cmd_err   = err_q;

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    if (accept && !idx_bad && (cmd_op == OP_CLEAR)) begin
      t_load = 1'b1;
      t_val  = TW'(SETTLE);
    end else if (accept && (cmd_op == OP_CLEAR_ALL)) begin
      t_load = 1'b1;
      t_val  = TW'(SETTLE);
    end else if (state == ST_ARM) begin
      t_load = 1'b1;
      t_val  = TW'(SET_HOLD);
    end else if (state == ST_RELEASE) begin
      t_load = 1'b1;
      t_val  = TW'(SETTLE);
    end
  end

  c_grid_hold_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tgt_row <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_SET: begin
                if (idx_bad) begin
                  err_q <= 1'b1;
                end else begin
                  // Column rises first with rows low: set cells hold, target not yet set.
                  col_q   <= col_q | cell_mask;
                  tgt_row <= cmd_row;
                  state   <= ST_ARM;
                end
              end
              OP_CLEAR: begin
                if (idx_bad) begin
                  err_q <= 1'b1;
                end else begin
                  // Rows are already low, so dropping the column clears the cell.
                  col_q <= col_q & ~cell_mask;
                  state <= ST_SETTLE;
                end
              end
              OP_CLEAR_ALL: begin
                col_q <= '0;
                state <= ST_SETTLE;
              end
              default: ;
            endcase
          end
        end
        ST_ARM: begin
          row_q <= 3'b001 << tgt_row;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (t_done) begin
            row_q <= '0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (t_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          row_q <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef READBACK_CHECK_EN
  logic       chk_q;
  logic [2:0] col_or;

  always_comb begin
    col_or = '0;
    for (int c = 0; c < GRID_COLS; c++) begin
      col_or[c] = col_q[c] | col_q[3 + c] | col_q[6 + c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
    end else if ((state == ST_SETTLE) && t_done && (col_any_i != col_or)) begin
      chk_q <= 1'b1;
    end
  end

  assign chk_err = chk_q;
`else
  logic unused_col_any;
  assign unused_col_any = ^col_any_i;
  assign chk_err        = 1'b0;
`endif

endmodule

// File: tb/tb_c_grid_write_sequencer.sv
// tb/tb_c_grid_write_sequencer.sv - randomized self-checking bench for c_grid_write_sequencer
module tb_c_grid_write_sequencer;

  localparam int SET_HOLD = 4;
  localparam int SETTLE   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_row = 2'b00;
  logic [1:0] cmd_col = 2'b00;
  logic [2:0] row_o;
  logic [8:0] col_o;
  logic [8:0] shadow_o;
  logic       busy;
  logic       cmd_err;
  logic [2:0] col_any = 3'b000;
  logic       chk_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0] m_shadow = 9'h000;
  logic       force_any = 1'b0;
  int         exp_lat, exp_row_cnt, exp_row_first;
  logic       exp_err;
  logic [2:0] exp_row;

  // Observations of the last command
  int         r_lat, r_first, r_cnt, r_bad;
  logic [8:0] r_col1;
  logic       r_err1;

  always #5 clk = ~clk;

  c_grid_write_sequencer #(.SET_HOLD(SET_HOLD), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .row_o     (row_o),
    .col_o     (col_o),
    .shadow_o  (shadow_o),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .col_any_i (col_any),
    .chk_err   (chk_err)
  );

  function automatic logic [2:0] col_or(input logic [8:0] g);
    logic [2:0] o;
    for (int c = 0; c < 3; c++) o[c] = g[c] | g[3 + c] | g[6 + c];
    return o;
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    m_shadow  = 9'h000;
    force_any = 1'b0;
    col_any   = 3'b000;
  endtask

  // Drive one command from idle and record what the grid lines did until ready returns.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] r, input logic [1:0] c);
    logic [8:0] prev_col;
    logic       ok_idx;
    logic       fin;
    int         k;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: ready=%0b required 1", cmd_ready);
    end
    ok_idx        = (r != 2'd3) && (c != 2'd3);
    exp_err       = 1'b0;
    exp_row       = 3'b000;
    exp_row_cnt   = 0;
    exp_row_first = -1;
    exp_lat       = 1;
    if (op == 2'b01 && ok_idx) begin
      m_shadow[int'(r) * 3 + int'(c)] = 1'b1;
      exp_row       = 3'b001 << r;
      exp_row_cnt   = SET_HOLD;
      exp_row_first = 2;
      exp_lat       = 3 + SET_HOLD + SETTLE;
    end else if (op == 2'b10 && ok_idx) begin
      m_shadow[int'(r) * 3 + int'(c)] = 1'b0;
      exp_lat = 1 + SETTLE;
    end else if (op == 2'b11) begin
      m_shadow = 9'h000;
      exp_lat  = 1 + SETTLE;
    end else if (op != 2'b00) begin
      exp_err = 1'b1;
    end
    if (!force_any) col_any = col_or(m_shadow);
    prev_col  = col_o;
    cmd_op    = op;
    cmd_row   = r;
    cmd_col   = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    k       = 1;
    r_col1  = col_o;
    r_err1  = cmd_err;
    r_lat   = -1;
    r_first = -1;
    r_cnt   = 0;
    r_bad   = 0;
    fin     = 1'b0;
    while (!fin && k <= 60) begin
      if (row_o != 3'b000) begin
        if (row_o != exp_row) r_bad++;
        else begin
          if (r_first < 0) r_first = k;
          r_cnt++;
        end
      end
      if (col_o != prev_col && row_o != 3'b000) r_bad++;
      if (cmd_ready) begin
        r_lat = k;
        fin   = 1'b1;
      end else begin
        prev_col = col_o;
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({row_o, col_o, shadow_o, cmd_err, busy, chk_err} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: row=%b col=%h sh=%h err=%b busy=%b chk=%b required all 0",
               row_o, col_o, shadow_o, cmd_err, busy, chk_err);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || row_o !== 3'b000 || col_o !== 9'h000 || shadow_o !== 9'h000) begin
      errors++;
      $display("FAIL reset_idle: ready=%b row=%b col=%h sh=%h required 1/0/0/0", cmd_ready, row_o, col_o, shadow_o);
    end
  endtask

  task automatic test_set_timing();
    apply_reset();
    do_cmd(2'b01, 2'd1, 2'd2);
    checks++;
    if (r_col1 !== 9'h020) begin
      errors++; $display("FAIL set_col_rise: col=%h required 020", r_col1);
    end
    checks++;
    if (r_first != 2 || r_cnt != SET_HOLD || r_bad != 0) begin
      errors++; $display("FAIL set_row_strobe: first=%0d cnt=%0d bad=%0d required 2/%0d/0", r_first, r_cnt, r_bad, SET_HOLD);
    end
    checks++;
    if (r_lat != 9) begin
      errors++; $display("FAIL set_latency: got %0d required 9", r_lat);
    end
    checks++;
    if (shadow_o !== 9'h020 || col_o !== 9'h020 || row_o !== 3'b000) begin
      errors++; $display("FAIL set_shadow: sh=%h col=%h row=%b required 020/020/0", shadow_o, col_o, row_o);
    end
  endtask

  task automatic test_set_clear();
    apply_reset();
    do_cmd(2'b01, 2'd0, 2'd0);
    do_cmd(2'b01, 2'd0, 2'd1);
    do_cmd(2'b10, 2'd0, 2'd0);
    checks++;
    if (col_o !== 9'h002 || shadow_o !== 9'h002) begin
      errors++; $display("FAIL set_clear_state: col=%h sh=%h required 002/002", col_o, shadow_o);
    end
    checks++;
    if (r_cnt != 0 || r_bad != 0 || r_lat != 1 + SETTLE) begin
      errors++; $display("FAIL clear_no_row: rowcnt=%0d bad=%0d lat=%0d required 0/0/%0d", r_cnt, r_bad, r_lat, 1 + SETTLE);
    end
    // Clearing an already-clear cell still runs only the settle interval
    do_cmd(2'b10, 2'd2, 2'd0);
    checks++;
    if (r_lat != 1 + SETTLE || col_o !== 9'h002) begin
      errors++; $display("FAIL clear_clear_cell: lat=%0d col=%h required %0d/002", r_lat, col_o, 1 + SETTLE);
    end
  endtask

  task automatic test_clear_all();
    apply_reset();
    do_cmd(2'b01, 2'd2, 2'd2);
    checks++;
    if (col_o !== 9'h100) begin
      errors++; $display("FAIL set22: col=%h required 100", col_o);
    end
    do_cmd(2'b11, 2'd0, 2'd0);
    checks++;
    if (col_o !== 9'h000 || shadow_o !== 9'h000 || r_lat != 3) begin
      errors++; $display("FAIL clear_all: col=%h sh=%h lat=%0d required 0/0/3", col_o, shadow_o, r_lat);
    end
  endtask

  task automatic test_invalid();
    apply_reset();
    do_cmd(2'b01, 2'd1, 2'd1);
    do_cmd(2'b01, 2'd3, 2'd1);
    checks++;
    if (r_err1 !== 1'b1 || r_lat != 1) begin
      errors++; $display("FAIL invalid_err: err=%b lat=%0d required 1/1", r_err1, r_lat);
    end
    checks++;
    if (col_o !== 9'h010 || shadow_o !== 9'h010 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL invalid_state: col=%h sh=%h ready=%b required 010/010/1", col_o, shadow_o, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL invalid_pulse_width: err=%b required 0", cmd_err);
    end
  endtask

  task automatic test_random();
    logic [1:0] op, r, c;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(3, 0));
      r  = 2'($urandom_range(3, 0));
      c  = 2'($urandom_range(3, 0));
      if (op == 2'b11 && $urandom_range(3, 0) != 0) op = 2'b01;
      do_cmd(op, r, c);
      checks++;
      if (r_lat != exp_lat || r_err1 !== exp_err) begin
        errors++; $display("FAIL rand_timing[%0d] op=%0d r=%0d c=%0d: lat=%0d err=%b required %0d/%b",
                           n, op, r, c, r_lat, r_err1, exp_lat, exp_err);
      end
      checks++;
      if (r_cnt != exp_row_cnt || r_first != exp_row_first || r_bad != 0) begin
        errors++; $display("FAIL rand_rows[%0d]: cnt=%0d first=%0d bad=%0d required %0d/%0d/0",
                           n, r_cnt, r_first, r_bad, exp_row_cnt, exp_row_first);
      end
      checks++;
      if (shadow_o !== m_shadow || col_o !== m_shadow || row_o !== 3'b000 || chk_err !== 1'b0) begin
        errors++; $display("FAIL rand_state[%0d]: sh=%h col=%h row=%b chk=%b required %h/%h/0/0",
                           n, shadow_o, col_o, row_o, chk_err, m_shadow, m_shadow);
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    int k;
    apply_reset();
    cmd_op = 2'b01; cmd_row = 2'd0; cmd_col = 2'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (row_o == 3'b000 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (row_o !== 3'b001 || col_o !== 9'h002) begin
      errors++; $display("FAIL strobe_reached: row=%b col=%h required 001/002", row_o, col_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (row_o !== 3'b000 || col_o !== 9'h000 || shadow_o !== 9'h000) begin
      errors++; $display("FAIL async_reset: row=%b col=%h sh=%h required 0/0/0", row_o, col_o, shadow_o);
    end
    apply_reset();
  endtask

`ifdef READBACK_CHECK_EN
  task automatic test_readback();
    apply_reset();
    do_cmd(2'b01, 2'd0, 2'd2);
    checks++;
    if (chk_err !== 1'b0) begin
      errors++; $display("FAIL readback_match: chk=%b required 0", chk_err);
    end
    force_any = 1'b1;
    col_any   = 3'b001;
    do_cmd(2'b01, 2'd0, 2'd1);
    checks++;
    if (chk_err !== 1'b1) begin
      errors++; $display("FAIL readback_mismatch: chk=%b required 1", chk_err);
    end
    force_any = 1'b0;
    do_cmd(2'b00, 2'd0, 2'd0);
    do_cmd(2'b10, 2'd0, 2'd1);
    checks++;
    if (chk_err !== 1'b1) begin
      errors++; $display("FAIL readback_sticky: chk=%b required 1", chk_err);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (chk_err !== 1'b0) begin
      errors++; $display("FAIL readback_reset: chk=%b required 0", chk_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_set_timing();
    test_set_clear();
    test_clear_all();
    test_invalid();
    test_random();
    test_reset_mid_strobe();
`ifdef READBACK_CHECK_EN
    test_readback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
